// File: rtl/tournament_predictor_param.sv
// Tournament branch predictor: local, global (gshare) and chooser counter tables
// with a power-up initialisation sweep and a single outstanding-branch snapshot.
module tournament_predictor_param #(
   parameter int LOCAL_BITS = 4,
   parameter int GHIST_LEN  = 8,
   parameter int CTR_WIDTH  = 2,
   parameter int GSHARE     = 1,
   parameter int PC_SHIFT   = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch_decode_sig,
   input  logic [31:0] pc_branch_addr,
   input  logic [31:0] offset,
   input  logic        update_valid,
   input  logic        update_taken,
   output logic        prediction,
   output logic [31:0] out_branch_addr,
   output logic        ready,
   output logic [15:0] mispredict_count
);

   localparam int IDX_BITS     = (LOCAL_BITS > GHIST_LEN) ? LOCAL_BITS : GHIST_LEN;
   localparam int LOCAL_DEPTH  = 1 << LOCAL_BITS;
   localparam int GLOBAL_DEPTH = 1 << GHIST_LEN;
   localparam logic [CTR_WIDTH-1:0] CTR_WEAK_T = {1'b1, {(CTR_WIDTH-1){1'b0}}};
   localparam logic [CTR_WIDTH-1:0] CTR_WEAK_L = {1'b0, {(CTR_WIDTH-1){1'b1}}};
   localparam logic [CTR_WIDTH-1:0] CTR_MAX    = '1;
   localparam logic [IDX_BITS-1:0]  IDX_LAST   = '1;

   typedef enum logic {ST_INIT, ST_READY} state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [CTR_WIDTH-1:0]   r_local   [LOCAL_DEPTH];
   logic [CTR_WIDTH-1:0]   r_chooser [LOCAL_DEPTH];
   logic [CTR_WIDTH-1:0]   r_global  [GLOBAL_DEPTH];
   logic [IDX_BITS-1:0]    r_idx;
   logic [GHIST_LEN-1:0]   r_ghist;
   logic                   r_snap_valid;
   logic [LOCAL_BITS-1:0]  r_snap_li;
   logic [GHIST_LEN-1:0]   r_snap_gi;
   logic                   r_snap_lp;
   logic                   r_snap_gp;
   logic                   r_snap_pred;
   logic [15:0]            r_mispredict;

   logic                   w_ready;
   logic [LOCAL_BITS-1:0]  w_li;
   logic [IDX_BITS-1:0]    w_li_ext;
   logic [GHIST_LEN-1:0]   w_gi;
   logic                   w_lp;
   logic                   w_gp;
   logic                   w_sel;
   logic                   w_pred;
   logic                   w_capture;
   logic                   w_update;
   logic                   w_unused_pc;

   function automatic logic [CTR_WIDTH-1:0] sat_step(input logic [CTR_WIDTH-1:0] ctr,
                                                      input logic up);
      logic [CTR_WIDTH-1:0] res;
      res = ctr;
      if (up && (ctr != CTR_MAX))
         res = ctr + CTR_WIDTH'(1);
      else if (!up && (ctr != '0))
         res = ctr - CTR_WIDTH'(1);
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= ST_INIT;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT:  if (r_idx == IDX_LAST) w_state_next = ST_READY;
         default:  w_state_next = r_state;
      endcase
   end

   assign w_ready     = (r_state == ST_READY) && !reset;
   assign w_li        = pc_branch_addr[PC_SHIFT +: LOCAL_BITS];
   assign w_unused_pc = ^pc_branch_addr;

   always_comb begin
      w_li_ext = '0;
      w_li_ext[LOCAL_BITS-1:0] = w_li;
      w_gi = (GSHARE != 0) ? (r_ghist ^ w_li_ext[GHIST_LEN-1:0]) : r_ghist;
   end

   // Reads see table/ghist contents from before this edge's update.
   assign w_lp   = r_local[w_li][CTR_WIDTH-1];
   assign w_gp   = r_global[w_gi][CTR_WIDTH-1];
   assign w_sel  = r_chooser[w_li][CTR_WIDTH-1];
   assign w_pred = w_sel ? w_gp : w_lp;

   // update_valid is a one-cycle pulse that resolves the captured branch; it is
   // consumed only when a snapshot is held, otherwise it is dropped silently.
   assign w_capture = branch_decode_sig && w_ready;
   assign w_update  = update_valid && r_snap_valid && w_ready;

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (r_state == ST_INIT) begin
            if ((r_idx >> LOCAL_BITS) == '0) begin
               r_local[r_idx[LOCAL_BITS-1:0]]   <= CTR_WEAK_T;
               r_chooser[r_idx[LOCAL_BITS-1:0]] <= CTR_WEAK_L;
            end
            if ((r_idx >> GHIST_LEN) == '0)
               r_global[r_idx[GHIST_LEN-1:0]] <= CTR_WEAK_T;
         end else if (w_update) begin
            r_local[r_snap_li]  <= sat_step(r_local[r_snap_li], update_taken);
            r_global[r_snap_gi] <= sat_step(r_global[r_snap_gi], update_taken);
            if (r_snap_lp != r_snap_gp)
               r_chooser[r_snap_li] <= sat_step(r_chooser[r_snap_li],
                                                r_snap_gp == update_taken);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx        <= '0;
         r_ghist      <= '0;
         r_snap_valid <= 1'b0;
         r_mispredict <= '0;
      end else begin
         if (r_state == ST_INIT)
            r_idx <= r_idx + IDX_BITS'(1);
         if (w_update) begin
            r_ghist      <= (r_ghist << 1) | GHIST_LEN'(update_taken);
            r_snap_valid <= 1'b0;
            if ((r_snap_pred != update_taken) && (r_mispredict != 16'hFFFF))
               r_mispredict <= r_mispredict + 16'd1;
         end
         // A capture in the same cycle wins over the clear above.
         if (w_capture) begin
            r_snap_valid <= 1'b1;
            r_snap_li    <= w_li;
            r_snap_gi    <= w_gi;
            r_snap_lp    <= w_lp;
            r_snap_gp    <= w_gp;
            r_snap_pred  <= w_pred;
         end
      end
   end

   assign prediction       = w_capture && w_pred;
   assign out_branch_addr  = pc_branch_addr + offset;
   assign ready            = w_ready;
   assign mispredict_count = r_mispredict;

endmodule

// File: doc/tournament_predictor_param.md
Name: tournament_predictor_param

Overview:
- Parametrised next-generation tournament branch predictor for the sail-core fetch/decode path.
- Holds a per-PC local counter table, a global table indexed by gshare (or pure global history), and a per-PC chooser table.
- Adds synchronous reset with a table-initialisation sweep, a configurable counter width and history length, and a single-entry prediction snapshot.
- All updates happen on the rising edge; no negedge logic.

Parameters:
- LOCAL_BITS, 4: local and chooser table index width; 2^LOCAL_BITS entries each.
- GHIST_LEN, 8: global history length and global table index width; 2^GHIST_LEN entries.
- CTR_WIDTH, 2: saturating counter width for all tables, minimum 2.
- GSHARE, 1: 1 = global index is ghist XOR pc index bits; 0 = ghist only.
- PC_SHIFT, 0: PC bits dropped before indexing. Index = pc[PC_SHIFT +: n].

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- branch_decode_sig  in  1  decode stage holds a branch.
- pc_branch_addr  in  32  PC of the branch in decode.
- offset  in  32  branch immediate.
- update_valid  in  1  one-cycle pulse: the resolved outcome of the outstanding branch is present.
- update_taken  in  1  actual branch decision.
- prediction  out  1  predicted taken.
- out_branch_addr  out  32  pc_branch_addr + offset, modulo 2^32, combinational.
- ready  out  1  initialisation complete.
- mispredict_count  out  16  resolved mispredictions, saturating at 0xFFFF.

Behaviour:
- Reset, while asserted:
  - state <= INIT, idx <= 0, ghist <= 0, snap_valid <= 0, mispredict_count <= 0.
  - ready = 0 and prediction = 0.
- INIT sweep (reset low):
  - Each cycle writes entry idx of every table whose depth exceeds idx.
  - Local and global counters are written to weakly taken: 1 << (CTR_WIDTH-1).
  - Chooser counters are written to weakly local: (1 << (CTR_WIDTH-1)) - 1.
  - idx increments each cycle. After writing idx = 2^max(LOCAL_BITS, GHIST_LEN) - 1 the state moves to READY and ready = 1 next cycle.
  - Defaults give 256 INIT cycles.
  - Reset asserted mid-INIT restarts the sweep at idx 0.
  - update_valid and branch_decode_sig are ignored in INIT.
- Prediction (READY, combinational):
  - li = local index; gi = ghist XOR li, zero-extended to GHIST_LEN (when GSHARE = 1).
  - lp = msb(local[li]), gp = msb(global[gi]), sel = msb(chooser[li]).
  - prediction = branch_decode_sig & ready & (sel ? gp : lp).
- Snapshot:
  - On branch_decode_sig & ready, capture li, gi, lp, gp and the final prediction; set snap_valid = 1.
  - The pipeline guarantees at most one unresolved branch. A new capture overwrites the snapshot.
- Update (READY, update_valid & snap_valid), all at the same posedge:
  - local[snap li] and global[snap gi] step toward update_taken: +1 saturating at 2^CTR_WIDTH-1, -1 saturating at 0. Counters never wrap.
  - Chooser[snap li] changes only when snap lp != snap gp: +1 (saturating) if gp == update_taken, else -1 (saturating).
  - ghist <= {ghist[GHIST_LEN-2:0], update_taken}.
  - If snap prediction != update_taken, mispredict_count +1, holding at 0xFFFF.
  - snap_valid <= 0, unless a new capture occurs in the same cycle.
- update_valid with snap_valid = 0: ignored, no state change.
- Same-cycle predict and update:
  - prediction uses pre-update table and ghist contents (read-before-write).
  - The update uses the old snapshot; the new snapshot is then captured.

Test Plan:
- Init: assert reset 3 cycles then release; hold decode = 1. Required: ready = 0 and prediction = 0 for exactly 256 cycles, ready = 1 at cycle 256. Then pc = 0x100, offset = 0x20 gives prediction = 1 and out_branch_addr = 0x120.
- Reset mid-init: pulse reset at INIT cycle 100. Required: ready stays 0 for a further full 256 cycles after release. An update_valid issued during INIT leaves all tables unchanged.
- Local training:
  - Predict pc = 0x4, then update not-taken. Required: prediction = 1, local[4] = 01, ghist = 0, mispredict_count = 1.
  - Predict pc = 0x4 again. Required: prediction = 0.
  - Update not-taken again. Required: local[4] = 00, mispredict_count = 1.
- Saturation: 5 predict/update-taken pairs at pc = 0x8. Required: local[8] = 11, no wrap.
  - Then 4 not-taken pairs give 00; a 5th not-taken pair keeps 00.
  - With GSHARE = 1, ghist afterwards = 8'b1110_0000.
- Chooser: alternate T/N at pc = 0xC for 16 branches. Required:
  - chooser[0xC] increments only on cycles where the snapshot lp != gp and gp is correct, reaching 11.
  - Final 4 predictions follow the global table and all are correct.
- Same-cycle collision: update pc = 0x4 (counter 01 -> 10) in the same cycle as a new decode at pc = 0x4. Required: prediction = 0 (pre-update value); the next decode at 0x4 gives 1; snap_valid stays 1.
